// File: rtl/nios_system_timer_driver_pkg.sv
// Shared constants and types for the interval-timer driver.
package nios_system_timer_driver_pkg;

  // Timer slave word addresses.
  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  // Control register bit indices.
  localparam int unsigned CTRL_ITO   = 0;
  localparam int unsigned CTRL_CONT  = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_STOP  = 3;

  // Status register bit index.
  localparam int unsigned STAT_TO = 0;

  typedef enum logic [3:0] {
    StIdle,
    StWrPl,
    StWrPh,
    StWrCtrl,
    StRun,
    StRdStat,
    StRdWait,
    StClrStat,
    StWrStop
  } state_e;

  // Builds a control register word from its individual bits.
  function automatic logic [15:0] ctrl_word(input logic stop, input logic start,
                                            input logic cont, input logic ito);
    logic [15:0] w;
    w             = '0;
    w[CTRL_STOP]  = stop;
    w[CTRL_START] = start;
    w[CTRL_CONT]  = cont;
    w[CTRL_ITO]   = ito;
    return w;
  endfunction

endpackage

// File: rtl/nios_system_timer_driver.sv
// Avalon-MM initiator that programs an interval timer and services its irq in hardware.
module nios_system_timer_driver
  import nios_system_timer_driver_pkg::*;
#(
  parameter logic [31:0] DEFAULT_PERIOD = 32'd49999,
  parameter bit          CONTINUOUS     = 1'b1,
  parameter int unsigned TICK_W         = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  input  logic              halt,
  input  logic              cfg_load,
  input  logic [31:0]       cfg_period,
  output logic [2:0]        av_address,
  output logic              av_chipselect,
  output logic              av_write_n,
  output logic [15:0]       av_writedata,
  input  logic [15:0]       av_readdata,
  input  logic              timer_irq,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [TICK_W-1:0] spurious_count,
  output logic              running,
  output logic              busy
);

  localparam logic [15:0] CtrlStart = ctrl_word(1'b0, 1'b1, CONTINUOUS, 1'b1);
  localparam logic [15:0] CtrlStop  = ctrl_word(1'b1, 1'b0, 1'b0, 1'b0);

  state_e      state_q, state_d;
  logic        pending_go_q, pending_go_d;
  logic        pending_halt_q, pending_halt_d;
  logic [31:0] period_q;
  logic [31:0] seq_period_q;
  logic        to_q;

  logic [2:0]  addr_d;
  logic        cs_d;
  logic        write_n_d;
  logic [15:0] wdata_d;

  // Only the TO bit of status matters here.
  logic unused_readdata;
  assign unused_readdata = ^av_readdata[15:1];

  // Next-state and pending-request tracking.
  always_comb begin
    state_d        = state_q;
    pending_go_d   = pending_go_q;
    pending_halt_d = pending_halt_q;

    // Requests arriving mid-sequence are remembered until the sequence completes.
    if (state_q != StIdle && state_q != StRun && state_q != StWrStop) begin
      if (go)   pending_go_d   = 1'b1;
      if (halt) pending_halt_d = 1'b1;
    end

    unique case (state_q)
      StIdle:   if (go) state_d = StWrPl;
      StWrPl:   state_d = StWrPh;
      StWrPh:   state_d = StWrCtrl;
      StWrCtrl: state_d = StRun;
      StRun: begin
        if (halt || pending_halt_q) begin
          state_d = StWrStop;
        end else if (timer_irq) begin
          state_d = StRdStat;
          // A go lost to the irq is replayed after the service.
          if (go) pending_go_d = 1'b1;
        end else if (go || pending_go_q) begin
          state_d      = StWrPl;
          pending_go_d = 1'b0;
        end
      end
      StRdStat:  state_d = StRdWait;
      StRdWait:  state_d = StClrStat;
      StClrStat: state_d = StRun;
      StWrStop: begin
        state_d        = StIdle;
        pending_go_d   = 1'b0;
        pending_halt_d = 1'b0;
      end
      default:   state_d = StIdle;
    endcase
  end

  // Bus cycle for the state being entered, so registered outputs line up with state_q.
  always_comb begin
    addr_d    = ADDR_STATUS;
    cs_d      = 1'b0;
    write_n_d = 1'b1;
    wdata_d   = '0;
    unique case (state_d)
      StWrPl: begin
        // Sequence period is latched on this same edge, so take it from period_q.
        addr_d    = ADDR_PERIOD_L;
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        wdata_d   = period_q[15:0];
      end
      StWrPh: begin
        addr_d    = ADDR_PERIOD_H;
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        wdata_d   = seq_period_q[31:16];
      end
      StWrCtrl: begin
        addr_d    = ADDR_CONTROL;
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        wdata_d   = CtrlStart;
      end
      StRdStat: begin
        addr_d = ADDR_STATUS;
        cs_d   = 1'b1;
      end
      StRdWait: addr_d = ADDR_STATUS;
      StClrStat: begin
        addr_d    = ADDR_STATUS;
        cs_d      = 1'b1;
        write_n_d = 1'b0;
      end
      StWrStop: begin
        addr_d    = ADDR_CONTROL;
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        wdata_d   = CtrlStop;
      end
      default: ;
    endcase
  end

  // State, configuration and bus output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      pending_go_q   <= 1'b0;
      pending_halt_q <= 1'b0;
      period_q       <= DEFAULT_PERIOD;
      seq_period_q   <= DEFAULT_PERIOD;
      av_address     <= ADDR_STATUS;
      av_chipselect  <= 1'b0;
      av_write_n     <= 1'b1;
      av_writedata   <= '0;
    end else begin
      state_q        <= state_d;
      pending_go_q   <= pending_go_d;
      pending_halt_q <= pending_halt_d;
      if (cfg_load) period_q <= cfg_period;
      if (state_d == StWrPl && state_q != StWrPl) seq_period_q <= period_q;
      av_address     <= addr_d;
      av_chipselect  <= cs_d;
      av_write_n     <= write_n_d;
      av_writedata   <= wdata_d;
    end
  end

  // Status capture, counters and running flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_q           <= 1'b0;
      tick_count     <= '0;
      spurious_count <= '0;
      running        <= 1'b0;
    end else begin
      if (state_q == StRdWait) to_q <= av_readdata[STAT_TO];
      if (state_q == StClrStat) begin
        if (to_q) tick_count     <= tick_count + TICK_W'(1);
        else      spurious_count <= spurious_count + TICK_W'(1);
      end
      if (state_q == StWrCtrl) running <= 1'b1;
      if (state_q == StWrStop) running <= 1'b0;
    end
  end

  assign tick = (state_q == StClrStat) && to_q;
  assign busy = (state_q != StIdle) && (state_q != StRun);

endmodule

// File: tb/tb_nios_system_timer_driver.sv
// Directed self-checking bench for nios_system_timer_driver.
module tb_nios_system_timer_driver;

  localparam int unsigned TickW = 4;

  logic             clk;
  logic             reset_n;
  logic             go;
  logic             halt;
  logic             cfg_load;
  logic [31:0]      cfg_period;
  logic [2:0]       av_address;
  logic             av_chipselect;
  logic             av_write_n;
  logic [15:0]      av_writedata;
  logic [15:0]      av_readdata;
  logic             timer_irq;
  logic             tick;
  logic [TickW-1:0] tick_count;
  logic [TickW-1:0] spurious_count;
  logic             running;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [TickW-1:0] exp_tick = '0;
  logic [TickW-1:0] exp_spur = '0;

  nios_system_timer_driver #(
    .DEFAULT_PERIOD(32'd49999),
    .CONTINUOUS    (1'b1),
    .TICK_W        (TickW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .go            (go),
    .halt          (halt),
    .cfg_load      (cfg_load),
    .cfg_period    (cfg_period),
    .av_address    (av_address),
    .av_chipselect (av_chipselect),
    .av_write_n    (av_write_n),
    .av_writedata  (av_writedata),
    .av_readdata   (av_readdata),
    .timer_irq     (timer_irq),
    .tick          (tick),
    .tick_count    (tick_count),
    .spurious_count(spurious_count),
    .running       (running),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {chipselect, write_n, address, writedata}
  logic [20:0] bus;
  assign bus = {av_chipselect, av_write_n, av_address, av_writedata};

  function automatic logic [20:0] bw(input logic [2:0] a, input logic [15:0] d);
    return {1'b1, 1'b0, a, d};
  endfunction

  localparam logic [20:0] BusIdle = {1'b0, 1'b1, 3'd0, 16'h0000};
  localparam logic [20:0] BusRead = {1'b1, 1'b1, 3'd0, 16'h0000};

  task automatic test_reset;
    reset_n = 1'b0; go = 0; halt = 0; cfg_load = 0; cfg_period = '0;
    av_readdata = '0; timer_irq = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus !== BusIdle) begin
      n_fail++; $display("FAIL reset_bus: got %h want %h", bus, BusIdle);
    end
    n_checks++;
    if ({tick, running, busy, tick_count, spurious_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_flags: got tick=%b run=%b busy=%b tc=%0d sc=%0d want all 0",
               tick, running, busy, tick_count, spurious_count);
    end
  endtask

  // Expects the three programming writes starting at the next negedge; go pulse already driven.
  task automatic expect_program(input logic [31:0] per, input string name);
    @(negedge clk);
    go = 0; halt = 0;
    n_checks++;
    if (bus !== bw(3'd2, per[15:0])) begin
      n_fail++; $display("FAIL %s_pl: got %h want %h", name, bus, bw(3'd2, per[15:0]));
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL %s_busy: got %b want 1", name, busy);
    end
  endtask

  task automatic expect_program_tail(input logic [31:0] per, input string name);
    @(negedge clk);
    cfg_load = 0;
    n_checks++;
    if (bus !== bw(3'd3, per[31:16])) begin
      n_fail++; $display("FAIL %s_ph: got %h want %h", name, bus, bw(3'd3, per[31:16]));
    end
    @(negedge clk);
    n_checks++;
    if (bus !== bw(3'd1, 16'h0007)) begin
      n_fail++; $display("FAIL %s_ctrl: got %h want %h", name, bus, bw(3'd1, 16'h0007));
    end
    @(negedge clk);
    n_checks++;
    if ({bus, running, busy} !== {BusIdle, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL %s_run: got bus=%h run=%b busy=%b want bus=%h run=1 busy=0",
               name, bus, running, busy, BusIdle);
    end
  endtask

  task automatic test_program;
    cfg_load = 1; cfg_period = 32'h0001_86A0;
    @(negedge clk);
    cfg_load = 0; go = 1;
    expect_program(32'h0001_86A0, "prog");
    expect_program_tail(32'h0001_86A0, "prog");
  endtask

  // Full irq service starting from a RUN cycle; optional halt pulse during RD_STAT.
  task automatic do_service(input logic [15:0] rd, input logic halt_in_rd, input string name);
    timer_irq = 1;
    @(negedge clk);
    n_checks++;
    if (bus !== BusRead) begin
      n_fail++; $display("FAIL %s_rd: got %h want %h", name, bus, BusRead);
    end
    if (halt_in_rd) halt = 1;
    @(negedge clk);
    halt = 0;
    av_readdata = rd;
    n_checks++;
    if ({bus, tick} !== {BusIdle, 1'b0}) begin
      n_fail++; $display("FAIL %s_wait: got %h/%b want %h/0", name, bus, tick, BusIdle);
    end
    @(negedge clk);
    av_readdata = 16'h0000;
    n_checks++;
    if ({bus, tick} !== {bw(3'd0, 16'h0000), rd[0]}) begin
      n_fail++;
      $display("FAIL %s_clr: got %h/tick=%b want %h/tick=%b", name, bus, tick,
               bw(3'd0, 16'h0000), rd[0]);
    end
    if (rd[0]) exp_tick = exp_tick + 1'b1;
    else       exp_spur = exp_spur + 1'b1;
    @(negedge clk);
    timer_irq = 0;
    n_checks++;
    if ({bus, tick, tick_count, spurious_count} !== {BusIdle, 1'b0, exp_tick, exp_spur}) begin
      n_fail++;
      $display("FAIL %s_after: got bus=%h tick=%b tc=%0d sc=%0d want bus=%h tick=0 tc=%0d sc=%0d",
               name, bus, tick, tick_count, spurious_count, BusIdle, exp_tick, exp_spur);
    end
    @(negedge clk);
    if (halt_in_rd) begin
      n_checks++;
      if (bus !== bw(3'd1, 16'h0008)) begin
        n_fail++; $display("FAIL %s_stop: got %h want %h", name, bus, bw(3'd1, 16'h0008));
      end
      @(negedge clk);
      n_checks++;
      if ({bus, running, busy} !== {BusIdle, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL %s_idle: got bus=%h run=%b busy=%b want bus=%h run=0 busy=0",
                 name, bus, running, busy, BusIdle);
      end
    end else begin
      n_checks++;
      if ({bus, busy, running} !== {BusIdle, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL %s_noresvc: got bus=%h busy=%b run=%b want bus=%h busy=0 run=1",
                 name, bus, busy, running, BusIdle);
      end
    end
  endtask

  task automatic test_service;
    do_service(16'h0003, 1'b0, "svc");
  endtask

  task automatic test_spurious;
    do_service(16'h0002, 1'b0, "spur");
  endtask

  task automatic test_halt_in_service;
    do_service(16'h0003, 1'b1, "halt");
  endtask

  // go with halt in IDLE (go wins) and cfg_load mid-sequence (old period kept).
  task automatic test_go_halt_cfg_mid;
    go = 1; halt = 1;
    expect_program(32'h0001_86A0, "gohalt");
    cfg_load = 1; cfg_period = 32'hABCD_1234;
    expect_program_tail(32'h0001_86A0, "gohalt");
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 14; i++) begin
      do_service((i % 2 == 0) ? 16'h0001 : 16'hFFFF, 1'b0, "wrap");
    end
    n_checks++;
    if (tick_count !== 4'd0) begin
      n_fail++; $display("FAIL wrap_count: got %0d want 0", tick_count);
    end
    n_checks++;
    if (spurious_count !== 4'd1) begin
      n_fail++; $display("FAIL wrap_spur: got %0d want 1", spurious_count);
    end
  endtask

  // Re-go from RUN uses the new period; reset during WR_PH drops chipselect at once.
  task automatic test_reset_mid;
    go = 1;
    expect_program(32'hABCD_1234, "rego");
    @(negedge clk);
    n_checks++;
    if (bus !== bw(3'd3, 16'hABCD)) begin
      n_fail++; $display("FAIL rego_ph: got %h want %h", bus, bw(3'd3, 16'hABCD));
    end
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if (av_chipselect !== 1'b0) begin
      n_fail++; $display("FAIL rst_cs: got %b want 0", av_chipselect);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus, running, busy, tick_count, spurious_count} !== {BusIdle, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL rst_after: got bus=%h run=%b busy=%b tc=%0d sc=%0d want idle and zeros",
               bus, running, busy, tick_count, spurious_count);
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_service();
    test_spurious();
    test_halt_in_service();
    test_go_halt_cfg_mid();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
